// File: rtl/vga_counter_overlay_if.sv
// ============================================================================
// vga_counter_overlay_if : control, counter and pixel bus for the counter overlay
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_counter_overlay_if #(
  parameter int NUM_CH = 24,
  parameter int VAL_W  = 8
);
  logic                      frame_start;
  logic [NUM_CH*VAL_W-1:0]   vals_flat;
  logic [NUM_CH*10-1:0]      pos_x_flat;
  logic [NUM_CH*9-1:0]       pos_y_flat;
  logic [9:0]                vga_col;
  logic [8:0]                vga_row;
  logic [11:0]               pixel_data;
  logic                      pixel_hit;
  logic                      busy;
  logic                      overrun;

  modport master (
    output frame_start, vals_flat, pos_x_flat, pos_y_flat, vga_col, vga_row,
    input  pixel_data, pixel_hit, busy, overrun
  );

  modport slave (
    input  frame_start, vals_flat, pos_x_flat, pos_y_flat, vga_col, vga_row,
    output pixel_data, pixel_hit, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/vga_counter_overlay.sv
// ============================================================================
// vga_counter_overlay : N-channel seven-segment counter overlay with one shared
// double-dabble engine. Optional macro VGA_OVERLAY_LZB_EN: leading-zero blanking.
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_counter_overlay #(
  parameter int          NUM_CH      = 24,
  parameter int          VAL_W       = 8,
  parameter int          DIGITS      = 3,
  parameter int          DIGIT_PITCH = 12,
  parameter logic [11:0] FG_COLOR    = 12'hFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_counter_overlay_if.slave  bus
);

  localparam int c_CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_CNTW  = $clog2(VAL_W) + 1;
  localparam int c_KW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_DW    = 4 * DIGITS;
  localparam int c_NFULL = (VAL_W + 2) / 3;
  localparam int c_NB    = (c_NFULL > DIGITS) ? c_NFULL : DIGITS;
  localparam int c_BW    = 4 * c_NB;
  localparam int c_SPAN  = DIGITS * DIGIT_PITCH;
  localparam logic [63:0] c_MAXV = (64'd10 ** DIGITS) - 64'd1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOAD   = 2'd1;
  localparam logic [1:0] c_SHIFT  = 2'd2;
  localparam logic [1:0] c_COMMIT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [c_CHW-1:0]  ch_q, ch_d;
  logic [c_CNTW-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic [VAL_W-1:0]  snap_q   [NUM_CH];
  logic [c_DW-1:0]   shadow_q [NUM_CH];
  logic [c_DW-1:0]   disp_q   [NUM_CH];
  logic [VAL_W-1:0]  bin_q;
  logic [c_BW-1:0]   bcd_q;

  logic [c_BW-1:0]   w_bcd_adj, w_bcd_next;
  logic [c_DW-1:0]   w_result;
  logic              w_sat, w_last_shift;

  always_comb begin
    w_bcd_adj = bcd_q;
    for (int n = 0; n < c_NB; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) w_bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  assign w_bcd_next   = (w_bcd_adj << 1) | c_BW'(bin_q[VAL_W-1]);
  // Values beyond the displayable range are clamped to all nines.
  assign w_sat        = 64'(snap_q[ch_q]) > c_MAXV;
  assign w_result     = w_sat ? {DIGITS{4'h9}} : w_bcd_next[c_DW-1:0];
  assign w_last_shift = (cnt_q == c_CNTW'(VAL_W - 1));

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    overrun_d = overrun_q | (bus.frame_start & busy_q);
    case (state_q)
      c_IDLE: if (bus.frame_start) begin
        ch_d    = '0;
        busy_d  = 1'b1;
        state_d = c_LOAD;
      end
      c_LOAD: begin
        cnt_d   = '0;
        state_d = c_SHIFT;
      end
      c_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (w_last_shift) begin
          if (ch_q == c_CHW'(NUM_CH - 1)) begin
            state_d = c_COMMIT;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = c_LOAD;
          end
        end
      end
      c_COMMIT: begin
        busy_d  = 1'b0;
        state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= c_IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // Display registers only move in COMMIT so a frame never shows mixed values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i]   <= '0;
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        c_IDLE: if (bus.frame_start) begin
          for (int i = 0; i < NUM_CH; i++) snap_q[i] <= bus.vals_flat[i*VAL_W +: VAL_W];
        end
        c_LOAD: begin
          bin_q <= snap_q[ch_q];
          bcd_q <= '0;
        end
        c_SHIFT: begin
          bin_q <= bin_q << 1;
          bcd_q <= w_bcd_next;
          if (w_last_shift) shadow_q[ch_q] <= w_result;
        end
        default: begin
          for (int i = 0; i < NUM_CH; i++) disp_q[i] <= shadow_q[i];
        end
      endcase
    end
  end

  logic [10:0]       w_dx [NUM_CH];
  logic [9:0]        w_dy [NUM_CH];
  logic [NUM_CH-1:0] w_in;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [9:0] w_px;
    logic [8:0] w_py;
    assign w_px     = bus.pos_x_flat[gi*10 +: 10];
    assign w_py     = bus.pos_y_flat[gi*9 +: 9];
    assign w_dx[gi] = {1'b0, bus.vga_col} - {1'b0, w_px};
    assign w_dy[gi] = {1'b0, bus.vga_row} - {1'b0, w_py};
    assign w_in[gi] = (bus.vga_col >= w_px) && (bus.vga_row >= w_py) &&
                      (w_dx[gi] < 11'(c_SPAN)) && (w_dy[gi] < 10'd16);
  end

  logic              w_hit;
  logic [c_CHW-1:0]  w_sel;
  logic [10:0]       w_sel_dx, w_lx;
  logic [3:0]        w_sel_dy;
  logic [c_KW-1:0]   w_k;

  // Descending scan so the lowest-indexed overlapping channel wins.
  always_comb begin
    w_hit    = 1'b0;
    w_sel    = '0;
    w_sel_dx = '0;
    w_sel_dy = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        w_hit    = 1'b1;
        w_sel    = c_CHW'(i);
        w_sel_dx = w_dx[i];
        w_sel_dy = w_dy[i][3:0];
      end
    end
  end

  assign w_k  = c_KW'(w_sel_dx / 11'(DIGIT_PITCH));
  assign w_lx = w_sel_dx % 11'(DIGIT_PITCH);

  logic             hit1_q;
  logic [c_CHW-1:0] ch1_q;
  logic [c_KW-1:0]  k1_q;
  logic [2:0]       lx1_q;
  logic [3:0]       ly1_q;
  logic [11:0]      pix_q;
  logic             pix_hit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit1_q <= 1'b0;
      ch1_q  <= '0;
      k1_q   <= '0;
      lx1_q  <= '0;
      ly1_q  <= '0;
    end else begin
      hit1_q <= w_hit && (w_lx < 11'd8);
      ch1_q  <= w_sel;
      k1_q   <= w_k;
      lx1_q  <= w_lx[2:0];
      ly1_q  <= w_sel_dy;
    end
  end

  logic [c_DW-1:0] w_disp_sel;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg;
  logic            w_shown, w_mid, w_left, w_right, w_top, w_bot, w_lit;

  assign w_disp_sel = disp_q[ch1_q];
  assign w_nib      = 4'(w_disp_sel >> (4 * (DIGITS - 1 - int'(k1_q))));

`ifdef VGA_OVERLAY_LZB_EN
  assign w_shown = (k1_q == c_KW'(DIGITS - 1)) ||
                   ((w_disp_sel >> (4 * (DIGITS - 1 - int'(k1_q)))) != '0);
`else
  assign w_shown = 1'b1;
`endif

  // Segment order {a,b,c,d,e,f,g}.
  always_comb begin
    case (w_nib)
      4'd0:    w_seg = 7'b1111110;
      4'd1:    w_seg = 7'b0110000;
      4'd2:    w_seg = 7'b1101101;
      4'd3:    w_seg = 7'b1111001;
      4'd4:    w_seg = 7'b0110011;
      4'd5:    w_seg = 7'b1011011;
      4'd6:    w_seg = 7'b1011111;
      4'd7:    w_seg = 7'b1110000;
      4'd8:    w_seg = 7'b1111111;
      4'd9:    w_seg = 7'b1111011;
      default: w_seg = 7'b0000000;
    endcase
  end

  assign w_mid   = (lx1_q >= 3'd1) && (lx1_q <= 3'd6);
  assign w_left  = (lx1_q <= 3'd1);
  assign w_right = (lx1_q >= 3'd6);
  assign w_top   = (ly1_q >= 4'd1) && (ly1_q <= 4'd7);
  assign w_bot   = (ly1_q >= 4'd8) && (ly1_q <= 4'd14);
  assign w_lit   = (w_seg[6] && (ly1_q <= 4'd1) && w_mid)  ||
                   (w_seg[5] && w_right && w_top)           ||
                   (w_seg[4] && w_right && w_bot)           ||
                   (w_seg[3] && (ly1_q >= 4'd14) && w_mid)  ||
                   (w_seg[2] && w_left && w_bot)            ||
                   (w_seg[1] && w_left && w_top)            ||
                   (w_seg[0] && ((ly1_q == 4'd7) || (ly1_q == 4'd8)) && w_mid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q     <= '0;
      pix_hit_q <= 1'b0;
    end else begin
      pix_hit_q <= hit1_q && w_shown && w_lit;
      pix_q     <= (hit1_q && w_shown && w_lit) ? FG_COLOR : 12'h000;
    end
  end

  assign bus.pixel_data = pix_q;
  assign bus.pixel_hit  = pix_hit_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_counter_overlay.sv
// ============================================================================
// tb_vga_counter_overlay : randomized scoreboard bench for vga_counter_overlay
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_counter_overlay;

  localparam int NUM_CH = 24;
  localparam int VAL_W  = 8;
  localparam int DIGITS = 3;
  localparam int PITCH  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_counter_overlay_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W)) bus ();

  vga_counter_overlay #(
    .NUM_CH(NUM_CH), .VAL_W(VAL_W), .DIGITS(DIGITS),
    .DIGIT_PITCH(PITCH), .FG_COLOR(12'hFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int px[NUM_CH], py[NUM_CH], vals[NUM_CH], ref_disp[NUM_CH];
  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  logic probe_on = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0;

  string SEGSTR[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
  // Segment rectangles a..g as {x0, x1, y0, y1}, inclusive.
  int RECT[7][4] = '{'{1,6,0,1}, '{6,7,1,7}, '{6,7,8,14}, '{1,6,14,15},
                     '{0,1,8,14}, '{0,1,1,7}, '{1,6,7,8}};

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(int e);
    int p = 1;
    for (int j = 0; j < e; j++) p *= 10;
    return p;
  endfunction

  function automatic logic [11:0] exp_pix(int col, int row);
    for (int c = 0; c < NUM_CH; c++) begin
      if (row >= py[c] && row < py[c] + 16 && col >= px[c] && col < px[c] + DIGITS*PITCH) begin
        int dx = col - px[c];
        int k  = dx / PITCH;
        int lx = dx % PITCH;
        int ly = row - py[c];
        int d  = (ref_disp[c] / pow10(DIGITS-1-k)) % 10;
        string s = SEGSTR[d];
        if (lx >= 8) return 12'h000;
`ifdef VGA_OVERLAY_LZB_EN
        if (k < DIGITS-1 && ref_disp[c] < pow10(DIGITS-1-k)) return 12'h000;
`endif
        for (int j = 0; j < s.len(); j++) begin
          int si = int'(s[j]) - int'("a");
          if (lx >= RECT[si][0] && lx <= RECT[si][1] && ly >= RECT[si][2] && ly <= RECT[si][3])
            return 12'hFFF;
        end
        return 12'h000;
      end
    end
    return 12'h000;
  endfunction

  task automatic drive_static();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.vals_flat[i*VAL_W +: VAL_W] = VAL_W'(vals[i]);
      bus.pos_x_flat[i*10 +: 10]      = 10'(px[i]);
      bus.pos_y_flat[i*9 +: 9]        = 9'(py[i]);
    end
  endtask

  task automatic randomize_layout();
    for (int i = 0; i < NUM_CH; i++) begin
      vals[i] = int'($urandom_range(0, 255));
      px[i]   = int'($urandom_range(100, 160));
      py[i]   = int'($urandom_range(60, 90));
    end
  endtask

  // Pulses frame_start, counts busy cycles and, with ovr_at >= 0, re-pulses mid-conversion.
  task automatic run_frame(input int ovr_at, output int cycles);
    drive_static();
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 1000) begin
      bus.frame_start = (cycles == ovr_at);
      cycles++;
      @(negedge clk);
    end
    bus.frame_start = 1'b0;
    for (int i = 0; i < NUM_CH; i++) ref_disp[i] = (vals[i] > 999) ? 999 : vals[i];
  endtask

  task automatic probe_exp(int col, int row, logic [11:0] e);
    @(negedge clk);
    bus.vga_col = 10'(col);
    bus.vga_row = 9'(row);
    probe_on    = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic probe(int col, int row);
    probe_exp(col, row, exp_pix(col, row));
  endtask

  task automatic drain();
    @(negedge clk) probe_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic probe_area(int c);
    for (int dy = -1; dy <= 16; dy++)
      for (int dx = -1; dx <= DIGITS*PITCH; dx++)
        probe(px[c] + dx, py[c] + dy);
    drain();
  endtask

  task automatic probe_random(int n);
    for (int j = 0; j < n; j++)
      probe(int'($urandom_range(95, 200)), int'($urandom_range(55, 110)));
    drain();
  endtask

  always @(posedge clk) begin
    v1 <= probe_on;
    v2 <= v1;
  end

  always @(negedge clk) begin
    if (v2) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("pixel_data", bus.pixel_data, e);
        check("pixel_hit", bus.pixel_hit, (e != 12'h000) ? 1 : 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.frame_start = 1'b0;
    bus.vals_flat   = '0;
    bus.pos_x_flat  = '0;
    bus.pos_y_flat  = '0;
    bus.vga_col     = '0;
    bus.vga_row     = '0;
    for (int i = 0; i < NUM_CH; i++) ref_disp[i] = 0;
    randomize_layout();
    px[0] = 130; py[0] = 70;
    drive_static();

    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_pixel_data", bus.pixel_data, 0);
    check("reset_pixel_hit", bus.pixel_hit, 0);
    @(negedge clk) rst = 1'b1;

    probe_area(0);

    vals[0] = 205;
    run_frame(-1, cyc);
    check("busy_cycles_205", cyc, 217);
    check("overrun_clear", bus.overrun, 0);
    probe_exp(131, 70, 12'hFFF);
    probe_exp(138, 70, 12'h000);
    drain();
    probe_area(0);
    probe_random(300);

    vals[0] = 111; vals[1] = 188;
    px[1] = px[0]; py[1] = py[0];
    run_frame(-1, cyc);
    check("busy_cycles_overlap", cyc, 217);
    probe_exp(131, 70, 12'h000);
    drain();
    probe_area(0);

    vals[0] = 7;
    run_frame(-1, cyc);
`ifdef VGA_OVERLAY_LZB_EN
    probe_exp(136, 72, 12'h000);
`else
    probe_exp(136, 72, 12'hFFF);
`endif
    probe_exp(130 + 2*PITCH + 1, 70, 12'hFFF);
    drain();
    probe_area(0);

    for (int r = 0; r < 4; r++) begin
      randomize_layout();
      if (r == 0) vals[0] = 0;
      run_frame(-1, cyc);
      check("busy_cycles_rand", cyc, 217);
      probe_random(300);
      probe_area(0);
    end

    run_frame(50, cyc);
    check("overrun_set", bus.overrun, 1);
    check("busy_cycles_overrun", cyc, 217);
    repeat (5) @(negedge clk);
    check("overrun_sticky", bus.overrun, 1);
    check("busy_after_overrun", bus.busy, 0);
    probe_random(200);

    randomize_layout();
    vals[0] = 205; px[0] = 130; py[0] = 70;
    run_frame(-1, cyc);
    @(negedge clk);
    bus.vga_col = 10'd131;
    bus.vga_row = 9'd70;
    repeat (3) @(negedge clk);
    check("pre_reset_pixel", bus.pixel_data, 12'hFFF);
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
    repeat (30) @(negedge clk);
    check("busy_mid_conversion", bus.busy, 1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_busy", bus.busy, 0);
    check("async_reset_overrun", bus.overrun, 0);
    check("async_reset_pixel_data", bus.pixel_data, 0);
    check("async_reset_pixel_hit", bus.pixel_hit, 0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < NUM_CH; i++) ref_disp[i] = 0;
    repeat (2) @(negedge clk);
    check("busy_after_reset", bus.busy, 0);
    probe_area(0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
